// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage for the 8-bit byte FIFO. Pops one byte when the FIFO
// is non-empty and enable is high, then sends it as a UART frame on tx:
// start bit, D0..D7 (LSB first), optional even parity, 1 or 2 stop bits.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   PARITY_EN     1 = append even-parity bit after D7
//   STOP_BITS     1 or 2
// Ports
//   clk         rising-edge system clock
//   rst         synchronous active-high reset (truncates any frame in flight)
//   enable      1 = fetch new bytes; 0 = finish current frame, then idle
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     FIFO pop strobe (high only in FETCH)
//   tx          registered serial line, idles high
//   busy        high whenever the FSM is not idle
//   frame_done  one-cycle pulse on the last clk of the final stop bit
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned       CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
        if (enable && !fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d   = fifo_data;
        par_d     = ^fifo_data;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (stop_cnt_q == STOP_LAST) begin
            frame_done = 1'b1;
            stop_cnt_d = '0;
            // Back-to-back frames go straight to FETCH without an IDLE cycle.
            state_d    = (enable && !fifo_empty) ? S_FETCH : S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
      end
    endcase

    // tx is registered from the next state so the line changes on the same
    // edge the FSM enters a new bit, with no combinational path to the pin.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign fifo_rd = (state_q == S_FETCH);
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. Two instances share clk/rst:
//   lane 0: CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1
//   lane 1: CLKS_PER_BIT=4, PARITY_EN=1, STOP_BITS=2
// Each lane has a behavioural FIFO and a UART-receiver style monitor that
// rebuilds the expected frame from the popped byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] enable = 2'b11;
  logic [1:0] fifo_empty, fifo_rd, tx, busy, frame_done;
  logic [7:0] fifo_data [2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]),
    .busy(busy[0]), .frame_done(frame_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]),
    .busy(busy[1]), .frame_done(frame_done[1]));

  // ---------------- behavioural FIFOs ----------------
  logic [7:0]  fmem  [2][256];
  int unsigned ftail [2] = '{default: 0};
  int unsigned fhead [2] = '{default: 0};
  int unsigned rdcnt [2] = '{default: 0};
  logic [1:0]  underflow = 2'b00;

  assign fifo_empty[0] = (fhead[0] == ftail[0]);
  assign fifo_empty[1] = (fhead[1] == ftail[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd[i]) begin
        rdcnt[i] <= rdcnt[i] + 1;
        if (fhead[i] == ftail[i]) underflow[i] <= 1'b1;
        else begin
          fifo_data[i] <= fmem[i][fhead[i][7:0]];
          fhead[i]     <= fhead[i] + 1;
        end
      end
    end
  end

  // ---------------- frame monitor / reference ----------------
  int unsigned eptr   [2] = '{default: 0};
  int unsigned mcnt   [2] = '{default: 0};
  int unsigned fstart [2] = '{default: 0};
  int unsigned fdone  [2] = '{default: 0};
  int unsigned bad    [2] = '{default: 0};
  int unsigned lost   [2] = '{default: 0};
  int unsigned spur   [2] = '{default: 0};
  int unsigned mism   [2] = '{default: 0};
  logic [1:0]  inf = 2'b00;
  logic [1:0]  last_par = 2'b00;
  logic [7:0]  exb [2];
  logic [7:0]  rxb [2];
  logic [7:0]  last_rx [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin : lane
      int   flen;
      int   b;
      logic expbit;
      flen = (10 + 2 * i) * CPB;
      if (rst) begin
        lost[i] = lost[i] + (fhead[i] - eptr[i]) + (inf[i] ? 1 : 0);
        eptr[i] = fhead[i];
        inf[i]  = 1'b0;
      end else if (!inf[i]) begin
        if (frame_done[i]) spur[i] = spur[i] + 1;
        if (tx[i] == 1'b0) begin
          if (eptr[i] >= fhead[i]) spur[i] = spur[i] + 1;
          exb[i]  = fmem[i][eptr[i][7:0]];
          eptr[i] = eptr[i] + 1;
          inf[i]  = 1'b1;
          mcnt[i] = 0;
          mism[i] = 0;
          rxb[i]  = 8'h00;
          fstart[i] = fstart[i] + 1;
        end
      end
      if (!rst && inf[i]) begin
        b = int'(mcnt[i]) / CPB;
        if (b == 0)                expbit = 1'b0;
        else if (b <= 8)           expbit = exb[i][3'(b - 1)];
        else if (i == 1 && b == 9) expbit = ^exb[i];
        else                       expbit = 1'b1;
        if (tx[i] !== expbit) mism[i] = mism[i] + 1;
        if (frame_done[i] !== (int'(mcnt[i]) == flen - 1)) mism[i] = mism[i] + 1;
        if (!busy[i]) mism[i] = mism[i] + 1;
        if (int'(mcnt[i]) % CPB == CPB / 2) begin
          if (b >= 1 && b <= 8) rxb[i][3'(b - 1)] = tx[i];
          if (i == 1 && b == 9) last_par[i] = tx[i];
        end
        if (int'(mcnt[i]) == flen - 1) begin
          inf[i]     = 1'b0;
          fdone[i]   = fdone[i] + 1;
          last_rx[i] = rxb[i];
          if (mism[i] != 0 || rxb[i] != exb[i]) bad[i] = bad[i] + 1;
        end else begin
          mcnt[i] = mcnt[i] + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][ftail[i][7:0]] = b;
    ftail[i] = ftail[i] + 1;
  endtask

  task automatic wait_idle(input int i, input bit need_empty, input string name);
    int n;
    n = 0;
    tick();
    tick();
    while (n < 3000 && !(!busy[i] && (!need_empty || fifo_empty[i]))) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, (n < 3000) ? 0 : 1, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [7];
    logic [9:0]  w;
    int          m, dpos, n, cnt, sh;
    int unsigned bs, bd, brd, bl;

    vt[0] = '{8'ha4, 1'b1};
    vt[1] = '{8'h9d, 1'b1};
    vt[2] = '{8'h82, 1'b0};
    vt[3] = '{8'h00, 1'b0};
    vt[4] = '{8'hff, 1'b0};
    vt[5] = '{8'hf4, 1'b1};
    vt[6] = '{8'h01, 1'b1};

    // reset state
    repeat (3) tick();
    check("rst_tx", tx, 3);
    check("rst_busy", busy, 0);
    check("rst_rd", fifo_rd, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;

    // single 8'hf4 frame, latency and waveform on lane 0
    push(0, 8'hf4);
    tick();
    check("t1_rd_fetch", fifo_rd[0], 1);
    check("t1_busy", busy[0], 1);
    tick();
    check("t1_rd_load", fifo_rd[0], 0);
    check("t1_tx_load", tx[0], 1);
    tick();
    check("t1_tx_fall", tx[0], 0);
    w = {1'b1, 8'hf4, 1'b0};
    m = 0;
    dpos = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick();
      if (tx[0] !== w[c / 4]) m++;
      if (fifo_rd[0]) m++;
      if (frame_done[0]) begin
        if (dpos < 0) dpos = c;
        else m++;
      end
    end
    check("t1_wave", m, 0);
    check("t1_done_pos", dpos, 39);
    tick();
    check("t1_idle_busy", busy[0], 0);
    check("t1_idle_tx", tx[0], 1);
    check("t1_rd_count", int'(rdcnt[0]), 1);

    // parity table on lane 1
    for (int k = 0; k < 7; k++) begin
      push(1, vt[k].data);
      wait_idle(1, 1'b1, "t2");
      check("t2_par", last_par[1], vt[k].par);
      check("t2_data", last_rx[1], vt[k].data);
    end
    check("t2_bad_frames", int'(bad[1]), 0);

    // two stop bits with FIFO kept empty
    push(1, 8'h3c);
    n = 0;
    while (n < 20 && tx[1] !== 1'b0) begin tick(); n++; end
    check("t6_start_seen", (n < 20) ? 1 : 0, 1);
    cnt = 0; dpos = -1; sh = 0;
    while (busy[1] && cnt < 200) begin
      if (frame_done[1]) dpos = cnt;
      if (cnt >= 40 && tx[1]) sh++;
      tick();
      cnt++;
    end
    check("t6_len", cnt, 48);
    check("t6_done_pos", dpos, 47);
    check("t6_stop_high", sh, 8);
    check("t6_underflow", underflow[1], 0);

    // 17 back-to-back frames on lane 0
    enable[0] = 1'b0;
    for (int k = 0; k < 17; k++) push(0, 8'($urandom));
    bd = fdone[0];
    brd = rdcnt[0];
    enable[0] = 1'b1;
    n = 0; cnt = 0;
    while (fdone[0] < bd + 17 && n < 2000) begin
      tick();
      n++;
      if (fdone[0] >= bd + 17) break;
      if (!busy[0]) cnt++;
    end
    check("t3_timeout", (n < 2000) ? 0 : 1, 0);
    check("t3_idle_gaps", cnt, 0);
    check("t3_frames", int'(fdone[0] - bd), 17);
    check("t3_rd_pulses", int'(rdcnt[0] - brd), 17);
    check("t3_bad_frames", int'(bad[0]), 0);

    // enable drop during D3 of frame 2
    enable[0] = 1'b0;
    for (int k = 0; k < 4; k++) push(0, 8'($urandom));
    bs = fstart[0];
    bd = fdone[0];
    enable[0] = 1'b1;
    n = 0;
    while (!(fstart[0] == bs + 2 && inf[0] && mcnt[0] == 16) && n < 500) begin tick(); n++; end
    check("t4_reach_d3", (n < 500) ? 1 : 0, 1);
    enable[0] = 1'b0;
    brd = rdcnt[0];
    wait_idle(0, 1'b0, "t4");
    check("t4_frames", int'(fdone[0] - bd), 2);
    check("t4_no_rd", int'(rdcnt[0] - brd), 0);
    check("t4_tx", tx[0], 1);
    check("t4_busy", busy[0], 0);
    check("t4_queued", fifo_empty[0], 0);
    repeat (5) tick();
    check("t4_hold_rd", int'(rdcnt[0] - brd), 0);
    enable[0] = 1'b1;
    tick();
    check("t4_refetch", fifo_rd[0], 1);
    wait_idle(0, 1'b1, "t4b");
    check("t4_bad_frames", int'(bad[0]), 0);

    // reset during DATA
    push(0, 8'h5a);
    push(0, 8'hc3);
    bs = fstart[0];
    bd = fdone[0];
    bl = lost[0];
    n = 0;
    while (!(fstart[0] == bs + 1 && inf[0] && mcnt[0] == 10) && n < 500) begin tick(); n++; end
    check("t5_reach_data", (n < 500) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    check("t5_tx", tx[0], 1);
    check("t5_busy", busy[0], 0);
    check("t5_rd", fifo_rd[0], 0);
    rst = 1'b0;
    wait_idle(0, 1'b1, "t5");
    check("t5_frames", int'(fdone[0] - bd), 1);
    check("t5_next_byte", last_rx[0], 8'hc3);
    check("t5_lost", int'(lost[0] - bl), 1);
    check("t5_bad_frames", int'(bad[0]), 0);

    // randomized traffic on both lanes
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 15) == 0 && (ftail[i] - fhead[i]) < 16) push(i, 8'($urandom));
        if ($urandom_range(0, 99) == 0) enable[i] = ~enable[i];
      end
    end
    enable = 2'b11;
    wait_idle(0, 1'b1, "rnd0");
    wait_idle(1, 1'b1, "rnd1");
    for (int i = 0; i < 2; i++) begin
      check("rnd_bad_frames", int'(bad[i]), 0);
      check("rnd_spurious", int'(spur[i]), 0);
      check("rnd_underflow", underflow[i], 0);
      check("rnd_accounted", int'(fdone[i] + lost[i]), int'(ftail[i]));
      check("rnd_rd_count", int'(rdcnt[i]), int'(ftail[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
